// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits num_pulses high pulses of high_len cycles separated
// by low_len-cycle gaps, with abort, a completion strobe and fully registered outputs.
module pulse_train_gen #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] low_len,
    input  logic [CW-1:0] num_pulses,
    input  logic          abort,
    output logic          dout,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [CW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CW-1:0] high_len_q, high_len_d;
    logic [CW-1:0] low_len_q, low_len_d;
    logic          done_d;
    logic          dout_q, busy_q, done_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        high_len_d  = high_len_q;
        low_len_d   = low_len_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (num_pulses != '0 && high_len != '0) begin
                        state_d     = S_HIGH;
                        phase_cnt_d = high_len;
                        pulse_cnt_d = num_pulses;
                        high_len_d  = high_len;
                        low_len_d   = low_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_cnt_q == CNT_ONE) begin
                    if (pulse_cnt_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // A zero gap still gets one low cycle so every pulse has its own rising edge.
                        state_d     = S_LOW;
                        phase_cnt_d = (low_len_q == '0) ? CNT_ONE : low_len_q;
                        pulse_cnt_d = pulse_cnt_q - CNT_ONE;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - CNT_ONE;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_cnt_q == CNT_ONE) begin
                    state_d     = S_HIGH;
                    phase_cnt_d = high_len_q;
                end else begin
                    phase_cnt_d = phase_cnt_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change only on clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            pulse_cnt_q <= '0;
            high_len_q  <= '0;
            low_len_q   <= '0;
            dout_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            high_len_q  <= high_len_d;
            low_len_q   <= low_len_d;
            dout_q      <= (state_d == S_HIGH);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= done_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL have parameter CW, default 8, setting the width of all length/count inputs.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle request to begin a pulse train.
REQ-005 The block SHALL have port high_len  input  CW  high-phase length in cycles, sampled on accepted start.
REQ-006 The block SHALL have port low_len  input  CW  low-phase (gap) length in cycles, sampled on accepted start.
REQ-007 The block SHALL have port num_pulses  input  CW  number of high pulses in the train, sampled on accepted start.
REQ-008 The block SHALL have port abort  input  1  synchronous cancel of an active train.
REQ-009 The block SHALL have port dout  output  1  generated waveform, registered.
REQ-010 The block SHALL have port busy  output  1  high while a train is in progress, registered.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse on normal train completion, registered.

Function
REQ-012 The block SHALL implement states IDLE, HIGH, LOW, plus down-counters for phase cycles and remaining pulses.
REQ-013 In IDLE, start=1 with num_pulses!=0 and high_len!=0 SHALL be accepted: latch high_len, low_len, num_pulses; enter HIGH at the next edge.
REQ-014 In IDLE, start=1 with num_pulses==0 or high_len==0 SHALL be rejected: stay IDLE, dout=0, busy=0, done=1 for exactly one cycle at the next edge.
REQ-015 Latency: start sampled at edge k SHALL give dout=1 and busy=1 from edge k+1.
REQ-016 HIGH SHALL hold dout=1 for exactly latched high_len cycles.
REQ-017 After a non-final HIGH, LOW SHALL hold dout=0 for max(latched low_len,1) cycles, then return to HIGH; low_len==0 is treated as 1 so each pulse is a distinct rising edge.
REQ-018 After the final HIGH, the block SHALL go directly to IDLE with no trailing gap: dout=0, busy=0, done=1 in that same first cycle.
REQ-019 busy SHALL be 1 for exactly N*H + (N-1)*max(L,1) cycles per accepted train (N, H, L = latched values).
REQ-020 start while busy=1 SHALL be ignored; input changes during a train SHALL have no effect.
REQ-021 abort=1 while busy=1 SHALL force IDLE at the next edge: dout=0, busy=0, done=0.
REQ-022 abort=1 in IDLE SHALL have no effect; abort and start in the same IDLE cycle: abort wins, start is dropped, done stays 0.
REQ-023 start in the same cycle as the final-HIGH-to-IDLE transition SHALL be ignored; a new start is accepted from the first cycle busy=0.
REQ-024 Counters SHALL be CW bits with no wrap: full-scale values (2^CW-1) SHALL produce exactly that many cycles/pulses.

Reset
REQ-025 resetn=0 SHALL immediately (asynchronously) force IDLE, dout=0, busy=0, done=0 and clear all counters and latched parameters.
REQ-026 Reset asserted mid-train SHALL abandon the train with no done pulse; after release, the block waits for a new start.
REQ-027 Outputs SHALL be glitch-free registered values; no combinational path from inputs to dout/busy/done.

Verification
REQ-028 The bench SHALL cover: start with H=2, L=3, N=3 -> dout = 1,1,0,0,0,1,1,0,0,0,1,1 from edge k+1; busy 12 cycles; done=1 at edge k+13.
REQ-029 The bench SHALL cover: H=1, L=0, N=4 -> dout alternates 1,0,1,0,1,0,1 (gap forced to 1); an edge detector on dout gives 4 pulses.
REQ-030 The bench SHALL cover: N=0 or H=0 -> dout stays 0, busy stays 0, single-cycle done at edge k+1.
REQ-031 The bench SHALL cover: abort during the 2nd HIGH of an H=4, L=2, N=3 train -> dout=0, busy=0 next edge, no done; a new start is then accepted.
REQ-032 The bench SHALL cover: resetn pulsed low mid-LOW -> outputs 0 without waiting for clk; start repeated while busy -> train length unchanged.
REQ-033 The bench SHALL compare against a cycle-accurate reference model every cycle and check busy length against REQ-019 for randomized H, L, N.
